lfsr_ctrl_arbiter: RTL and testbench

- Shares one LFSR instance among `NUM_REQ` requesters using round-robin arbitration.
- For each granted request, sequences the LFSR's control pins: seed load, shift run, output enable, serial capture.
- Returns the captured `LFSR_WD`-bit word to the winner on a valid/ready response channel.
- Sits between the random-number consumers and the existing LFSR block, and is the only driver of that LFSR's control inputs.

---
 rtl/lfsr_ctrl_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/lfsr_ctrl_arbiter.sv | 149 ++++++++++++++
 tb/tb_lfsr_ctrl_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// rtl/lfsr_ctrl_pkg.sv - shared FSM encoding and fixed constants for lfsr_ctrl_arbiter
package lfsr_ctrl_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_OUTEN   = 3'd5;
    localparam logic [2:0] S_CAPTURE = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

    // serial bits captured per operation
    localparam int CAP_LEN = 8;
    // cycles the LFSR reset/seed-load pulse is held low
    localparam int LOAD_W  = 1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant combinational from registered pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    int            idx;

    // first active requester at or after the pointer, wrapping around
    always_comb begin
        gnt   = '0;
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = PW'(idx);
            end
        end
    end

    // pointer moves just past the winner whenever a grant is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_ctrl_arbiter.sv
// rtl/lfsr_ctrl_arbiter.sv - shares one LFSR among requesters; optional capture timeout via LFSR_CTRL_TIMEOUT_EN
module lfsr_ctrl_arbiter
    import lfsr_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LFSR_WD      = 8,
    parameter int SHIFT_CYCLES = 10,
    parameter int TIMEOUT      = 32
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [NUM_REQ*LFSR_WD-1:0] Seed_In,
    output logic [NUM_REQ-1:0]         Gnt,
    output logic                       Rsp_Valid,
    input  logic                       Rsp_Ready,
    output logic [$clog2(NUM_REQ)-1:0] Rsp_Id,
    output logic [LFSR_WD-1:0]         Rsp_Data,
    output logic                       Rsp_Err,
    output logic [LFSR_WD-1:0]         LFSR_Seed,
    output logic                       LFSR_Rst_n,
    output logic                       LFSR_Enable,
    output logic                       LFSR_Out_En,
    input  logic                       LFSR_Out,
    input  logic                       LFSR_Valid
);

    localparam int IW       = $clog2(NUM_REQ);
    localparam int CNT_MAX  = (SHIFT_CYCLES > TIMEOUT) ? SHIFT_CYCLES : TIMEOUT;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam logic [2:0] CAP_LAST = 3'(CAP_LEN - 1);

    logic [2:0]         state;
    logic [2:0]         state_n;
    logic [CW-1:0]      cnt;
    logic [2:0]         cap_cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               grant_now;
    logic [IW-1:0]      win_id;
    logic               timeout_hit;

    // Gnt is held low while reset is asserted even though Req may be high
    assign grant_now = (state == S_IDLE) && (|Req) && Reset;
    assign Gnt       = grant_now ? arb_gnt : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (Clock),
        .rst_n   (Reset),
        .req     (Req),
        .advance (grant_now),
        .gnt     (arb_gnt)
    );

    // index of the one-hot winner
    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) win_id = IW'(i);
        end
    end

`ifdef LFSR_CTRL_TIMEOUT_EN
    logic rsp_err_q;

    assign timeout_hit = (state == S_OUTEN) && !LFSR_Valid && (cnt == CW'(TIMEOUT - 1));
    assign Rsp_Err     = rsp_err_q;

    // error flag: cleared at grant, set when OUTEN gives up on LFSR_Valid
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rsp_err_q <= 1'b0;
        end else if (grant_now) begin
            rsp_err_q <= 1'b0;
        end else if (timeout_hit) begin
            rsp_err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign Rsp_Err     = 1'b0;
`endif

    // operation sequencer next-state
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (grant_now) state_n = S_LOAD;
            S_LOAD:    if (cnt == '0) state_n = S_SETTLE;
            S_SETTLE:  state_n = S_RUN;
            S_RUN:     if (cnt == '0) state_n = S_GAP;
            S_GAP:     state_n = S_OUTEN;
            S_OUTEN: begin
                if (LFSR_Valid)       state_n = S_CAPTURE;
                else if (timeout_hit) state_n = S_RESP;
            end
            S_CAPTURE: if (cap_cnt == CAP_LAST) state_n = S_RESP;
            S_RESP:    if (Rsp_Ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // state, counters, and registered LFSR / response outputs decoded from next state
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cap_cnt     <= '0;
            LFSR_Seed   <= '0;
            LFSR_Rst_n  <= 1'b1;
            LFSR_Enable <= 1'b0;
            LFSR_Out_En <= 1'b0;
            Rsp_Valid   <= 1'b0;
            Rsp_Id      <= '0;
            Rsp_Data    <= '0;
        end else begin
            state       <= state_n;
            LFSR_Rst_n  <= (state_n != S_LOAD);
            LFSR_Enable <= (state_n == S_RUN);
            LFSR_Out_En <= (state_n == S_OUTEN) || (state_n == S_CAPTURE);
            Rsp_Valid   <= (state_n == S_RESP);
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        LFSR_Seed <= Seed_In[win_id*LFSR_WD +: LFSR_WD];
                        Rsp_Id    <= win_id;
                        cnt       <= CW'(LOAD_W - 1);
                    end
                end
                S_LOAD:   if (cnt != '0) cnt <= cnt - 1'b1;
                S_SETTLE: cnt <= CW'(SHIFT_CYCLES - 1);
                S_RUN:    if (cnt != '0) cnt <= cnt - 1'b1;
                S_GAP: begin
                    cnt      <= '0;
                    cap_cnt  <= '0;
                    Rsp_Data <= '0;
                end
                S_OUTEN:  if (!LFSR_Valid) cnt <= cnt + 1'b1;
                S_CAPTURE: begin
                    Rsp_Data[cap_cnt] <= LFSR_Out;
                    cap_cnt           <= cap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_ctrl_arbiter.sv
// tb/tb_lfsr_ctrl_arbiter.sv - scoreboard bench for lfsr_ctrl_arbiter with LFSR stub
module tb_lfsr_ctrl_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SC = 10;

    logic           Clock = 1'b0;
    logic           Reset = 1'b0;
    logic [N-1:0]   Req = '0;
    logic [N*W-1:0] Seed_In = '0;
    logic [N-1:0]   Gnt;
    logic           Rsp_Valid;
    logic           Rsp_Ready = 1'b1;
    logic [1:0]     Rsp_Id;
    logic [W-1:0]   Rsp_Data;
    logic           Rsp_Err;
    logic [W-1:0]   LFSR_Seed;
    logic           LFSR_Rst_n;
    logic           LFSR_Enable;
    logic           LFSR_Out_En;
    logic           LFSR_Out;
    logic           LFSR_Valid;

    lfsr_ctrl_arbiter #(.NUM_REQ(N), .LFSR_WD(W), .SHIFT_CYCLES(SC), .TIMEOUT(32)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Seed_In(Seed_In), .Gnt(Gnt),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id), .Rsp_Data(Rsp_Data),
        .Rsp_Err(Rsp_Err), .LFSR_Seed(LFSR_Seed), .LFSR_Rst_n(LFSR_Rst_n),
        .LFSR_Enable(LFSR_Enable), .LFSR_Out_En(LFSR_Out_En), .LFSR_Out(LFSR_Out),
        .LFSR_Valid(LFSR_Valid)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] lfsr_run(input logic [7:0] s, input int n);
        logic [7:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    // external LFSR stub: loads on Rst_n low, steps on Enable, streams LSB first after Valid seen
    logic [7:0] stub_state = '0;
    logic [7:0] stub_sh    = '0;
    logic       stub_seen  = 1'b0;
    int         stub_oe    = 0;
    int         cur_dly    = 0;
    bit         force_zero = 1'b0;

    always @(posedge Clock) begin
        if (!LFSR_Rst_n)      stub_state <= LFSR_Seed;
        else if (LFSR_Enable) stub_state <= lfsr_step(stub_state);
        if (!LFSR_Out_En) begin
            stub_sh   <= stub_state;
            stub_seen <= 1'b0;
            stub_oe   <= 0;
        end else begin
            stub_oe <= stub_oe + 1;
            if (LFSR_Valid && !stub_seen) stub_seen <= 1'b1;
            else if (stub_seen)           stub_sh   <= stub_sh >> 1;
        end
    end

    assign LFSR_Valid = LFSR_Out_En && (stub_oe >= cur_dly);
    assign LFSR_Out   = stub_sh[0];

    // stimulus state shared between stimulus, driver and monitor
    logic [N-1:0] want        = '0;
    bit           hold_req    = 1'b0;
    bit           scramble    = 1'b0;
    bit           scr_pending = 1'b0;
    int           ready_mode  = 0;
    int           low_cnt     = 0;

    // input driver: updates inputs just after each rising edge
    initial forever begin
        @(posedge Clock);
        #1;
        if (scr_pending) begin
            Seed_In     = $urandom;
            scr_pending = 1'b0;
        end
        Req = want;
        case (ready_mode)
            0: Rsp_Ready = 1'b1;
            1: Rsp_Ready = 1'($urandom_range(0, 1));
            default: begin
                if (Rsp_Valid && low_cnt < 5) begin
                    Rsp_Ready = 1'b0;
                    low_cnt++;
                end else begin
                    Rsp_Ready = 1'b1;
                    if (!Rsp_Valid) low_cnt = 0;
                end
            end
        endcase
    end

    typedef struct {
        int         id;
        logic [7:0] seed;
        logic [7:0] data;
        int         t_gnt;
        int         dly;
    } exp_t;

    exp_t       q[$];
    int         gnt_log[$];
    int         model_ptr  = 0;
    bit         busy       = 1'b0;
    logic       prev_valid = 1'b0;
    bit         prev_hs    = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_id;
    logic       prev_err;
    int         rst_low    = 0;
    int         en_cnt     = 0;
    logic       prev_oe    = 1'b0;

    // monitor / scoreboard, sampling on the falling edge
    initial forever begin
        @(negedge Clock);
        if (!Reset) begin
            q.delete();
            busy = 0; model_ptr = 0; prev_valid = 0; prev_hs = 0;
            rst_low = 0; en_cnt = 0; prev_oe = 0; scr_pending = 0;
        end else begin
            if (!busy && Req != '0) begin
                int   ew;
                bit   fnd;
                exp_t e;
                ew = 0; fnd = 0;
                for (int k = 0; k < N; k++) begin
                    if (!fnd && Req[(model_ptr + k) % N]) begin
                        fnd = 1; ew = (model_ptr + k) % N;
                    end
                end
                check("gnt_winner", 32'(Gnt), 32'(1 << ew));
                model_ptr = (ew + 1) % N;
                busy      = 1;
                gnt_log.push_back(ew);
                cur_dly   = force_zero ? 0 : $urandom_range(0, 4);
                e.id      = ew;
                e.seed    = Seed_In[ew*W +: W];
                e.data    = lfsr_run(e.seed, SC);
                e.t_gnt   = cyc;
                e.dly     = cur_dly;
                q.push_back(e);
                if (!hold_req) want[ew] = 1'b0;
                if (scramble) scr_pending = 1'b1;
            end else begin
                check("gnt_idle", 32'(Gnt), 32'h0);
            end

            if (!LFSR_Rst_n) begin
                rst_low++;
            end else begin
                if (rst_low > 0) begin
                    check("rstn_width", rst_low, 1);
                    en_cnt = 0;
                end
                rst_low = 0;
            end
            if (LFSR_Enable) begin
                if (en_cnt == 0 && q.size() > 0) check("gnt_to_enable", cyc - q[$].t_gnt, 3);
                en_cnt++;
            end
            if (LFSR_Out_En && !prev_oe) check("enable_cycles", en_cnt, SC);
            prev_oe = LFSR_Out_En;

            if (prev_hs) check("valid_drop", 32'(Rsp_Valid), 32'h0);
            prev_hs = 0;
            if (Rsp_Valid) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rsp: id=%0d data=%0h with empty scoreboard", Rsp_Id, Rsp_Data);
                end else begin
                    if (!prev_valid) begin
                        check("latency", cyc - q[0].t_gnt, 23 + q[0].dly);
                        check("seed_held", 32'(LFSR_Seed), 32'(q[0].seed));
                    end else begin
                        check("hold_data", 32'(Rsp_Data), 32'(prev_data));
                        check("hold_id", 32'(Rsp_Id), 32'(prev_id));
                        check("hold_err", 32'(Rsp_Err), 32'(prev_err));
                    end
                    if (Rsp_Ready) begin
                        exp_t e;
                        e = q.pop_front();
                        check("rsp_id", 32'(Rsp_Id), 32'(e.id));
                        check("rsp_data", 32'(Rsp_Data), 32'(e.data));
                        check("rsp_err", 32'(Rsp_Err), 32'h0);
                        busy    = 0;
                        prev_hs = 1;
                    end
                end
            end
            prev_valid = Rsp_Valid && !prev_hs;
            prev_data  = Rsp_Data;
            prev_id    = Rsp_Id;
            prev_err   = Rsp_Err;
        end
    end

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while ((want != '0 || busy || Req != '0) && n < limit) begin
            @(negedge Clock);
            n++;
        end
        check({name, "_done"}, 32'(n < limit), 32'h1);
        repeat (2) @(negedge Clock);
        #1;
    endtask

    initial begin
        int start;
        int n;
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};

        repeat (3) @(posedge Clock);
        #1;
        check("rst_gnt", 32'(Gnt), 0);
        check("rst_valid", 32'(Rsp_Valid), 0);
        check("rst_id", 32'(Rsp_Id), 0);
        check("rst_data", 32'(Rsp_Data), 0);
        check("rst_err", 32'(Rsp_Err), 0);
        check("rst_seed", 32'(LFSR_Seed), 0);
        check("rst_lfsr_rstn", 32'(LFSR_Rst_n), 1);
        check("rst_enable", 32'(LFSR_Enable), 0);
        check("rst_out_en", 32'(LFSR_Out_En), 0);
        Reset = 1'b1;
        @(negedge Clock); #1;

        // fairness with all requests held
        Seed_In  = $urandom;
        hold_req = 1'b1;
        start    = gnt_log.size();
        want     = 4'b1111;
        n = 0;
        while (gnt_log.size() < start + 6 && n < 1000) begin
            @(negedge Clock); #1;
            n++;
        end
        want     = '0;
        hold_req = 1'b0;
        wait_done("fair", 400);
        check("fair_count", gnt_log.size() - start, 6);
        for (int i = 0; i < 6; i++) begin
            if (start + i < gnt_log.size()) check("fair_order", gnt_log[start + i], exp_order[i]);
        end

        // single request, best-case latency
        force_zero = 1'b1;
        Seed_In    = {8'h00, 8'h00, 8'h00, 8'b10010011};
        want       = 4'b0001;
        wait_done("single", 200);
        force_zero = 1'b0;

        // late seed change after grant
        scramble = 1'b1;
        Seed_In  = $urandom;
        want     = 4'b1000;
        wait_done("late_seed", 200);
        scramble = 1'b0;

        // explicit backpressure with another requester waiting
        ready_mode = 2;
        Seed_In    = $urandom;
        want       = 4'b0110;
        wait_done("backpressure", 400);

        // randomized traffic
        ready_mode = 1;
        for (int it = 0; it < 20; it++) begin
            Seed_In  = $urandom;
            scramble = 1'($urandom_range(0, 1));
            want     = 4'($urandom_range(1, 15));
            wait_done("random", 1000);
        end
        scramble   = 1'b0;
        ready_mode = 0;

        // reset in the middle of RUN
        Seed_In = $urandom;
        want    = 4'b0010;
        n = 0;
        while (!LFSR_Enable && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("run_reached", 32'(n < 100), 1);
        repeat (3) @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        check("mid_rst_enable", 32'(LFSR_Enable), 0);
        check("mid_rst_valid", 32'(Rsp_Valid), 0);
        check("mid_rst_rstn", 32'(LFSR_Rst_n), 1);
        check("mid_rst_out_en", 32'(LFSR_Out_En), 0);
        check("mid_rst_gnt", 32'(Gnt), 0);
        want = 4'b0100;
        repeat (2) @(posedge Clock);
        #2;
        Reset = 1'b1;
        @(negedge Clock); #1;
        check("regrant_after_reset", 32'(Gnt), 32'h4);
        wait_done("after_reset", 200);

        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
